// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared types, colours and reset positions for the scene compositor
package scene_pkg;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [2:0] {L_BG, L_NET, L_P2, L_P1, L_BALL} layer_t;

    localparam rgb12_t C_BG   = 12'h8CF;
    localparam rgb12_t C_P1   = 12'hF40;
    localparam rgb12_t C_P2   = 12'h04F;
    localparam rgb12_t C_BALL = 12'hFF0;
    localparam rgb12_t C_NET  = 12'hFFF;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic [9:0] p1_x;
        logic [9:0] p1_y;
        logic [9:0] p2_x;
        logic [9:0] p2_y;
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic       smash;
    } snapshot_t;

    localparam snapshot_t SNAP_RESET = '{
        p1_x: 10'd100, p1_y: 10'd352,
        p2_x: 10'd520, p2_y: 10'd352,
        ball_x: 10'd120, ball_y: 10'd50,
        smash: 1'b0
    };

    // Half-open span test done in 11 bits so a sprite near the right/bottom
    // edge clips instead of wrapping back to column/row 0.
    function automatic logic in_span(input logic [9:0] c, input logic [9:0] lo,
                                     input logic [10:0] len);
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + len));
    endfunction

endpackage

// File: rtl/scene_snapshot.sv
// rtl/scene_snapshot.sv - tear-free shadow/active double buffer of the physics snapshot
//   clk, rst_n      clock, asynchronous active-low reset
//   phys_valid      snapshot strobe, loads shadow (or active directly with frame_start)
//   frame_start     vertical-blank pulse, commits a pending shadow to active
//   snap_in         live snapshot inputs
//   active          snapshot used for rendering; changes only on frame_start
module scene_snapshot
    import scene_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      phys_valid,
    input  logic      frame_start,
    input  snapshot_t snap_in,
    output snapshot_t active
);

    snapshot_t shadow;
    logic      pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= SNAP_RESET;
            active  <= SNAP_RESET;
            pending <= 1'b0;
        end else if (phys_valid && frame_start) begin
            // Coincident strobe bypasses the shadow so the newest data is shown now.
            shadow  <= snap_in;
            active  <= snap_in;
            pending <= 1'b0;
        end else if (phys_valid) begin
            shadow  <= snap_in;
            pending <= 1'b1;
        end else if (frame_start && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/scene_compositor.sv
// rtl/scene_compositor.sv - renders players/ball/net per pixel from a double-buffered physics snapshot and keeps score
//   Optional macro SMASH_FLASH_EN: ball colour toggles to ~C_BALL every 4 frames while smashing.
//   clk, rst_n                 clock, asynchronous active-low reset
//   phys_valid + p1/p2/ball    physics snapshot strobe and positions, ball_is_smash flag
//   game_over, winner          point result, sampled on phys_valid
//   frame_start                start of vertical blank
//   pix_valid, h_cnt, v_cnt    visible pixel coordinate
//   rgb_out, rgb_valid         pixel colour, 2 cycles after the coordinate
//   p1_score, p2_score         saturating scores
//   match_over                 sticky match end flag
module scene_compositor
    import scene_pkg::*;
#(
    parameter int BALL_SZ   = 80,
    parameter int PLAYER_SZ = 128,
    parameter int NET_X0    = 317,
    parameter int NET_TOP   = 300,
    parameter int WIN_SCORE = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phys_valid,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic        ball_is_smash,
    input  logic        game_over,
    input  logic [1:0]  winner,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic [11:0] rgb_out,
    output logic        rgb_valid,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic        match_over
);

    localparam logic [10:0] BALL_LEN   = 11'(BALL_SZ);
    localparam logic [10:0] PLAYER_LEN = 11'(PLAYER_SZ);
    localparam logic [9:0]  NET_LEFT   = 10'(NET_X0);
    localparam logic [10:0] NET_ROW    = 11'(NET_TOP);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

    snapshot_t snap_in;
    snapshot_t active;

    assign snap_in = '{p1_x: p1_x, p1_y: p1_y, p2_x: p2_x, p2_y: p2_y,
                       ball_x: ball_x, ball_y: ball_y, smash: ball_is_smash};

    scene_snapshot u_snap (
        .clk         (clk),
        .rst_n       (rst_n),
        .phys_valid  (phys_valid),
        .frame_start (frame_start),
        .snap_in     (snap_in),
        .active      (active)
    );

    logic flash_s1;

`ifdef SMASH_FLASH_EN
    logic [2:0] flash_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= 3'd0;
            flash_s1  <= 1'b0;
        end else begin
            if (frame_start) flash_cnt <= flash_cnt + 3'd1;
            flash_s1 <= active.smash & flash_cnt[2];
        end
    end
`else
    logic unused_smash;
    assign unused_smash = active.smash;
    assign flash_s1     = 1'b0;
`endif

    // Stage 1: hit tests against the active snapshot.
    logic hit_ball_s1, hit_p1_s1, hit_p2_s1, hit_net_s1, pv_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_ball_s1 <= 1'b0;
            hit_p1_s1   <= 1'b0;
            hit_p2_s1   <= 1'b0;
            hit_net_s1  <= 1'b0;
            pv_s1       <= 1'b0;
        end else begin
            hit_ball_s1 <= in_span(h_cnt, active.ball_x, BALL_LEN) &&
                           in_span(v_cnt, active.ball_y, BALL_LEN);
            hit_p1_s1   <= in_span(h_cnt, active.p1_x, PLAYER_LEN) &&
                           in_span(v_cnt, active.p1_y, PLAYER_LEN);
            hit_p2_s1   <= in_span(h_cnt, active.p2_x, PLAYER_LEN) &&
                           in_span(v_cnt, active.p2_y, PLAYER_LEN);
            hit_net_s1  <= in_span(h_cnt, NET_LEFT, 11'd6) && ({1'b0, v_cnt} >= NET_ROW);
            pv_s1       <= pix_valid;
        end
    end

    // Stage 2: priority select, later assignments win.
    layer_t layer;
    rgb12_t colour;

    always_comb begin
        layer  = L_BG;
        colour = C_BG;
        if (hit_net_s1)  layer = L_NET;
        if (hit_p2_s1)   layer = L_P2;
        if (hit_p1_s1)   layer = L_P1;
        if (hit_ball_s1) layer = L_BALL;
        case (layer)
            L_NET:   colour = C_NET;
            L_P2:    colour = C_P2;
            L_P1:    colour = C_P1;
            L_BALL:  colour = flash_s1 ? ~C_BALL : C_BALL;
            default: colour = C_BG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_out   <= pv_s1 ? colour : '0;
            rgb_valid <= pv_s1;
        end
    end

    // Score: a point is a rising edge of game_over as seen across strobes.
    logic go_prev;
    logic point;

    assign point = phys_valid && game_over && !go_prev && !match_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_prev    <= 1'b0;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            match_over <= 1'b0;
        end else begin
            if (phys_valid) go_prev <= game_over;
            if (point && winner == 2'd1 && p1_score < WIN) p1_score <= p1_score + 4'd1;
            if (point && winner == 2'd2 && p2_score < WIN) p2_score <= p2_score + 4'd1;
            if (p1_score == WIN || p2_score == WIN) match_over <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scene_compositor.sv
// tb/tb_scene_compositor.sv - self-checking bench for scene_compositor
module tb_scene_compositor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phys_valid = 1'b0;
    logic [9:0]  p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0, ball_x = '0, ball_y = '0;
    logic        ball_is_smash = 1'b0;
    logic        game_over = 1'b0;
    logic [1:0]  winner = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  h_cnt = '0, v_cnt = '0;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [3:0]  p1_score, p2_score;
    logic        match_over;

    scene_compositor dut (
        .clk(clk), .rst_n(rst_n), .phys_valid(phys_valid),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .ball_x(ball_x), .ball_y(ball_y), .ball_is_smash(ball_is_smash),
        .game_over(game_over), .winner(winner), .frame_start(frame_start),
        .pix_valid(pix_valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid),
        .p1_score(p1_score), .p2_score(p2_score), .match_over(match_over)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] BG = 12'h8CF, P1 = 12'hF40, P2 = 12'h04F, BALL = 12'hFF0, NET = 12'hFFF;

    int n_pass = 0;
    int n_total = 0;

    // Model: positions as {p1x,p1y,p2x,p2y,bx,by}
    int  m_act[6];
    int  m_sh[6];
    bit  m_act_sm, m_sh_sm, m_pend, m_go_prev, m_mo;
    int  m_p1, m_p2, m_frames;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_act = '{100, 352, 520, 352, 120, 50};
        m_sh  = m_act;
        m_act_sm = 0; m_sh_sm = 0; m_pend = 0; m_go_prev = 0; m_mo = 0;
        m_p1 = 0; m_p2 = 0; m_frames = 0;
    endtask

    function automatic bit inside_box(int h, int v, int x, int y, int sz);
        return h >= x && h < x + sz && v >= y && v < y + sz;
    endfunction

    function automatic logic [11:0] m_rgb(int h, int v);
        logic [11:0] ball_c;
        ball_c = BALL;
`ifdef SMASH_FLASH_EN
        if (m_act_sm && (m_frames % 8) >= 4) ball_c = ~BALL;
`endif
        if (inside_box(h, v, m_act[4], m_act[5], 80)) return ball_c;
        if (inside_box(h, v, m_act[0], m_act[1], 128)) return P1;
        if (inside_box(h, v, m_act[2], m_act[3], 128)) return P2;
        if (h >= 317 && h < 323 && v >= 300) return NET;
        return BG;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic strobe(input int a, input int b, input int c, input int d, input int e, input int f,
                          input bit sm, input bit go, input int w, input bit fs);
        @(negedge clk);
        p1_x = 10'(a); p1_y = 10'(b); p2_x = 10'(c); p2_y = 10'(d);
        ball_x = 10'(e); ball_y = 10'(f); ball_is_smash = sm;
        game_over = go; winner = 2'(w);
        phys_valid = 1'b1; frame_start = fs;
        @(negedge clk);
        phys_valid = 1'b0; frame_start = 1'b0;
        if (fs) begin
            m_act = '{a, b, c, d, e, f}; m_act_sm = sm; m_pend = 0; m_frames++;
        end else begin
            m_sh = '{a, b, c, d, e, f}; m_sh_sm = sm; m_pend = 1;
        end
        if (go && !m_go_prev && !m_mo) begin
            if (w == 1 && m_p1 < 7) m_p1++;
            if (w == 2 && m_p2 < 7) m_p2++;
        end
        m_go_prev = go;
        if (m_p1 >= 7 || m_p2 >= 7) m_mo = 1;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (m_pend) begin
            m_act = m_sh; m_act_sm = m_sh_sm; m_pend = 0;
        end
        m_frames++;
    endtask

    task automatic pixel_chk(input string name, input int h, input int v, input logic [11:0] exp);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v); pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        chk({name, "_rgb"}, int'(rgb_out), int'(exp));
        chk({name, "_valid"}, int'(rgb_valid), 1);
    endtask

    task automatic chk_score(input string name);
        chk({name, "_p1"}, int'(p1_score), m_p1);
        chk({name, "_p2"}, int'(p2_score), m_p2);
        chk({name, "_mo"}, int'(match_over), int'(m_mo));
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [11:0] exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{130, 60, BALL};
        vt[1]  = '{0, 0, BG};
        vt[2]  = '{105, 360, P1};
        vt[3]  = '{520, 352, P2};
        vt[4]  = '{317, 300, NET};
        vt[5]  = '{316, 300, BG};
        vt[6]  = '{322, 479, NET};
        vt[7]  = '{323, 479, BG};
        vt[8]  = '{319, 299, BG};
        vt[9]  = '{199, 129, BALL};
        vt[10] = '{200, 129, BG};
        vt[11] = '{639, 479, P2};

        model_reset();
        #1;
        chk("reset_rgb", int'(rgb_out), 0);
        chk("reset_valid", int'(rgb_valid), 0);
        chk_score("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) pixel_chk($sformatf("vec%0d", i), vt[i].h, vt[i].v, vt[i].exp);

        @(negedge clk);
        chk("idle_rgb_zero", int'(rgb_out), 0);
        chk("idle_valid", int'(rgb_valid), 0);

        // Shadow write without frame_start must not disturb the image.
        strobe(100, 352, 520, 352, 300, 100, 0, 0, 0, 0);
        chk("pending_set", int'(dut.u_snap.pending), 1);
        pixel_chk("no_commit", 130, 60, BALL);
        frame();
        chk("pending_clr", int'(dut.u_snap.pending), 0);
        pixel_chk("commit_old", 130, 60, BG);
        pixel_chk("commit_new", 310, 110, BALL);

        // Last strobe before frame_start wins.
        strobe(100, 352, 520, 352, 10, 10, 0, 0, 0, 0);
        strobe(100, 352, 520, 352, 400, 20, 0, 0, 0, 0);
        frame();
        pixel_chk("last_wins_old", 15, 15, BG);
        pixel_chk("last_wins_new", 405, 25, BALL);

        // Coincident strobe and frame_start.
        strobe(100, 352, 520, 352, 150, 360, 0, 0, 0, 1);
        chk("coinc_pending", int'(dut.u_snap.pending), 0);
        pixel_chk("overlap_ball", 160, 370, BALL);
        pixel_chk("overlap_p1", 105, 470, P1);
        pixel_chk("overlap_net", 319, 400, NET);
        frame();
        pixel_chk("hold_ball", 160, 370, BALL);
        pixel_chk("hold_p1", 105, 470, P1);

        // Right-edge clipping: ball at x=600 must not wrap to column 0.
        strobe(100, 352, 520, 352, 600, 10, 0, 0, 0, 1);
        pixel_chk("clip_edge", 639, 20, BALL);
        pixel_chk("clip_nowrap", 5, 20, BG);

        // Randomized snapshots, commits, points and pixels against the model.
        for (int it = 0; it < 150; it++) begin
            int bx, by, hh, vv;
            bx = int'($urandom_range(0, 639));
            by = int'($urandom_range(0, 479));
            strobe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                   int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                   bx, by, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) frame();
            hh = (m_act[4] + int'($urandom_range(0, 99))) % 640;
            vv = (m_act[5] + int'($urandom_range(0, 99))) % 480;
            pixel_chk("rand_near", hh, vv, m_rgb(hh, vv));
            hh = int'($urandom_range(0, 639));
            vv = int'($urandom_range(0, 479));
            pixel_chk("rand_any", hh, vv, m_rgb(hh, vv));
            chk("rand_pending", int'(dut.u_snap.pending), int'(m_pend));
            chk_score("rand");
        end

        // Scoring from a clean reset.
        do_reset();
        strobe(100, 352, 520, 352, 120, 50, 0, 1, 3, 0);
        strobe(100, 352, 520, 352, 120, 50, 0, 0, 0, 0);
        chk_score("winner3");
        strobe(100, 352, 520, 352, 120, 50, 0, 1, 2, 0);
        strobe(100, 352, 520, 352, 120, 50, 0, 0, 0, 0);
        chk_score("p2_point");
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 3; j++) strobe(100, 352, 520, 352, 120, 50, 0, 1, 1, 0);
            if (k == 0) chk("held_once", int'(p1_score), 1);
            strobe(100, 352, 520, 352, 120, 50, 0, 0, 0, 0);
        end
        chk("p1_win_score", int'(p1_score), 7);
        chk("p1_match_over", int'(match_over), 1);
        strobe(100, 352, 520, 352, 120, 50, 0, 1, 1, 0);
        strobe(100, 352, 520, 352, 120, 50, 0, 0, 0, 0);
        strobe(100, 352, 520, 352, 120, 50, 0, 1, 2, 0);
        chk("eighth_ignored_p1", int'(p1_score), 7);
        chk("after_over_p2", int'(p2_score), 1);
        chk_score("after_over");

        // Smash flash across 8 frames.
        do_reset();
        strobe(100, 352, 520, 352, 300, 100, 1, 0, 0, 1);
        for (int f = 0; f < 8; f++) begin
            logic [11:0] e;
            e = BALL;
`ifdef SMASH_FLASH_EN
            if ((m_frames % 8) >= 4) e = ~BALL;
`endif
            pixel_chk($sformatf("smash_f%0d", f), 310, 110, e);
            frame();
        end

        // Mid-operation reset flushes the pipe and clears state.
        strobe(100, 352, 520, 352, 120, 50, 0, 1, 2, 0);
        @(negedge clk);
        h_cnt = 10'd130; v_cnt = 10'd60; pix_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", int'(rgb_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(rgb_valid), 0);
        chk("mid_rst_rgb", int'(rgb_out), 0);
        chk("mid_rst_p2", int'(p2_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("flush_1", int'(rgb_valid), 0);
        @(negedge clk);
        chk("flush_2", int'(rgb_valid), 1);
        chk("flush_rgb", int'(rgb_out), int'(BALL));
        pix_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
